// File: rtl/adxl345_pkg.sv
// -----------------------------------------------------------------------------
// adxl345_pkg
// Shared definitions for the ADXL345 burst reader: register addresses, fixed
// register values, the SPI shift-register width and the controller state type.
// Also provides a helper that builds an SPI command byte {R/W, MB, addr}.
// -----------------------------------------------------------------------------
package adxl345_pkg;

   localparam int SPI_W = 64;

   localparam logic [5:0] REG_DEVID       = 6'h00;
   localparam logic [5:0] REG_DATA_FORMAT = 6'h31;
   localparam logic [5:0] REG_POWER_CTL   = 6'h2D;
   localparam logic [5:0] REG_DATAX0      = 6'h32;

   localparam logic [7:0] DEVID_VALUE   = 8'hE5;
   localparam logic [7:0] POWER_MEASURE = 8'h08;

   typedef enum logic [3:0] {
      ST_READ_ID,
      ST_CHECK_ID,
      ST_WR_FORMAT,
      ST_WR_POWER,
      ST_WAIT_TIMER,
      ST_BURST,
      ST_ACCUM,
      ST_PUBLISH,
      ST_ERROR
   } state_e;

   function automatic logic [7:0] spi_cmd(input logic rd, input logic mb, input logic [5:0] addr);
      return {rd, mb, addr};
   endfunction

endpackage

// File: rtl/spi_mode3_shifter.sv
// -----------------------------------------------------------------------------
// spi_mode3_shifter
// SPI mode-3 master (clock idles high, MSB first). One transaction of ipLength
// bits is launched by ipStart while idle. nCS falls immediately, the first SClk
// fall comes one half-period later, SDI changes on SClk falls and SDO is
// sampled on SClk rises. nCS rises one half-period after the last rise, then
// the block stays busy for two more half-periods so nCS always idles high for
// at least that long before the next transaction.
// Ports:
//   ipClk, ipReset  clock, synchronous active-high reset
//   ipStart         launch a transaction (ignored while busy)
//   ipLength        number of bits to shift
//   ipData          transmit data, left-aligned (bit 63 sent first)
//   opData          received bits, right-aligned (last bit in bit 0)
//   opBusy          transaction in progress (including trailing nCS-high gap)
//   opDone          one-cycle strobe when the transaction has fully finished
//   nCS, SClk, SDI  SPI outputs; SDO SPI input
// -----------------------------------------------------------------------------
module spi_mode3_shifter
   import adxl345_pkg::*;
#(
   parameter int CLOCK_DIV = 5
) (
   input  logic             ipClk,
   input  logic             ipReset,
   input  logic             ipStart,
   input  logic [6:0]       ipLength,
   input  logic [SPI_W-1:0] ipData,
   output logic [SPI_W-1:0] opData,
   output logic             opBusy,
   output logic             opDone,
   output logic             nCS,
   output logic             SClk,
   output logic             SDI,
   input  logic             SDO
);

   logic [3:0]       div_q, div_d;
   logic [7:0]       hp_q, hp_d;
   logic [6:0]       len_q, len_d;
   logic [SPI_W-1:0] tx_q, tx_d;
   logic [SPI_W-1:0] rx_q, rx_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             ncs_q, ncs_d;
   logic             sclk_q, sclk_d;
   logic             sdi_q, sdi_d;

   logic             tick;
   logic [7:0]       hp_next;
   logic [7:0]       last_rise;

   assign tick      = busy_q && (div_q == 4'(CLOCK_DIV - 1));
   assign hp_next   = hp_q + 8'd1;
   assign last_rise = {len_q, 1'b0};

   // Half-period ticks are numbered from 1: odd ticks up to 2*len are SClk
   // falls, even ticks are rises; then nCS release and a two-tick idle guard.
   always_comb begin
      div_d  = div_q;
      hp_d   = hp_q;
      len_d  = len_q;
      tx_d   = tx_q;
      rx_d   = rx_q;
      busy_d = busy_q;
      done_d = 1'b0;
      ncs_d  = ncs_q;
      sclk_d = sclk_q;
      sdi_d  = sdi_q;
      if (!busy_q) begin
         if (ipStart) begin
            busy_d = 1'b1;
            ncs_d  = 1'b0;
            div_d  = '0;
            hp_d   = '0;
            len_d  = ipLength;
            tx_d   = ipData;
            rx_d   = '0;
         end
      end else begin
         div_d = tick ? 4'd0 : div_q + 4'd1;
         if (tick) begin
            hp_d = hp_next;
            if (hp_next <= last_rise) begin
               if (hp_next[0]) begin
                  sclk_d = 1'b0;
                  sdi_d  = tx_q[SPI_W-1];
                  tx_d   = {tx_q[SPI_W-2:0], 1'b0};
               end else begin
                  sclk_d = 1'b1;
                  rx_d   = {rx_q[SPI_W-2:0], SDO};
               end
            end else if (hp_next == last_rise + 8'd1) begin
               ncs_d = 1'b1;
               sdi_d = 1'b1;
            end else if (hp_next == last_rise + 8'd3) begin
               busy_d = 1'b0;
               done_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge ipClk) begin
      if (ipReset) begin
         div_q  <= '0;
         hp_q   <= '0;
         len_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         ncs_q  <= 1'b1;
         sclk_q <= 1'b1;
         sdi_q  <= 1'b1;
      end else begin
         div_q  <= div_d;
         hp_q   <= hp_d;
         len_q  <= len_d;
         busy_q <= busy_d;
         done_q <= done_d;
         ncs_q  <= ncs_d;
         sclk_q <= sclk_d;
         sdi_q  <= sdi_d;
      end
      tx_q <= tx_d;
      rx_q <= rx_d;
   end

   assign opData = rx_q;
   assign opBusy = busy_q;
   assign opDone = done_q;
   assign nCS    = ncs_q;
   assign SClk   = sclk_q;
   assign SDI    = sdi_q;

endmodule

// File: rtl/adxl345_burst_reader.sv
// -----------------------------------------------------------------------------
// adxl345_burst_reader
// ADXL345 SPI controller: verifies DEVID, programs DATA_FORMAT and POWER_CTL,
// then repeatedly reads X/Y/Z with one 6-byte multi-byte burst, optionally
// paced by a sample timer and box-car averaged over 2**AVG_LOG2 bursts.
// Ports:
//   ipClk, ipReset   clock, synchronous active-high reset
//   opX/opY/opZ      averaged axis values, two's complement, held between strobes
//   opValid          one-cycle strobe when opX/opY/opZ update
//   opError          sticky, set when DEVID does not read back as 8'hE5
//   nCS, SClk, SDI   SPI master outputs (mode 3); SDO SPI input
// -----------------------------------------------------------------------------
module adxl345_burst_reader
   import adxl345_pkg::*;
#(
   parameter int          CLOCK_DIV     = 5,
   parameter logic [1:0]  RANGE         = 2'b01,
   parameter bit          FULL_RES      = 1'b1,
   parameter int unsigned SAMPLE_PERIOD = 0,
   parameter int          AVG_LOG2      = 0
) (
   input  logic        ipClk,
   input  logic        ipReset,
   output logic [15:0] opX,
   output logic [15:0] opY,
   output logic [15:0] opZ,
   output logic        opValid,
   output logic        opError,
   output logic        nCS,
   output logic        SClk,
   output logic        SDI,
   input  logic        SDO
);

   localparam int               ACC_W        = 16 + AVG_LOG2;
   localparam int               CNT_W        = AVG_LOG2 + 1;
   localparam logic [CNT_W-1:0] CNT_TARGET   = CNT_W'(1 << AVG_LOG2);
   localparam logic [31:0]      TIMER_THRESH = (SAMPLE_PERIOD == 0) ? 32'd0 : 32'(SAMPLE_PERIOD - 1);

   state_e                  state_q, state_d;
   logic                    issued_q, issued_d;
   logic [31:0]             timer_q, timer_d;
   logic signed [ACC_W-1:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d, acc_z_q, acc_z_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
   logic [15:0]             x_q, x_d, y_q, y_d, z_q, z_d;
   logic                    valid_q, valid_d;
   logic                    error_q, error_d;

   logic                    spi_start;
   logic [6:0]              spi_len;
   logic [SPI_W-1:0]        spi_tx, spi_rx;
   logic                    spi_busy, spi_done;
   logic signed [15:0]      raw_x, raw_y, raw_z;
   logic                    unused_spi_rx;

   // Arithmetic shift floors the mean; the accumulator is wide enough that
   // the result always fits back into 16 bits.
   function automatic logic [15:0] avg_out(input logic signed [ACC_W-1:0] acc);
      logic signed [ACC_W-1:0] shifted;
      shifted = acc >>> AVG_LOG2;
      return shifted[15:0];
   endfunction

   // Burst reply bytes sit in opData[47:0] as X0,X1,Y0,Y1,Z0,Z1.
   assign raw_x         = {spi_rx[39:32], spi_rx[47:40]};
   assign raw_y         = {spi_rx[23:16], spi_rx[31:24]};
   assign raw_z         = {spi_rx[7:0],   spi_rx[15:8]};
   assign unused_spi_rx = ^spi_rx[63:48];
   assign cnt_inc       = cnt_q + CNT_W'(1);

   spi_mode3_shifter #(
      .CLOCK_DIV(CLOCK_DIV)
   ) u_spi (
      .ipClk   (ipClk),
      .ipReset (ipReset),
      .ipStart (spi_start),
      .ipLength(spi_len),
      .ipData  (spi_tx),
      .opData  (spi_rx),
      .opBusy  (spi_busy),
      .opDone  (spi_done),
      .nCS     (nCS),
      .SClk    (SClk),
      .SDI     (SDI),
      .SDO     (SDO)
   );

   // issued_q marks that the current state's single transaction has been
   // launched, so each configuration state issues exactly one transfer.
   always_comb begin
      state_d   = state_q;
      issued_d  = issued_q;
      timer_d   = (timer_q == '1) ? timer_q : timer_q + 32'd1;
      acc_x_d   = acc_x_q;
      acc_y_d   = acc_y_q;
      acc_z_d   = acc_z_q;
      cnt_d     = cnt_q;
      x_d       = x_q;
      y_d       = y_q;
      z_d       = z_q;
      valid_d   = 1'b0;
      error_d   = error_q;
      spi_start = 1'b0;
      spi_len   = 7'd16;
      spi_tx    = '0;
      case (state_q)
         ST_READ_ID: begin
            spi_tx = {spi_cmd(1'b1, 1'b0, REG_DEVID), 56'h0};
            if (!issued_q && !spi_busy) begin
               spi_start = 1'b1;
               issued_d  = 1'b1;
            end else if (spi_done) begin
               issued_d = 1'b0;
               state_d  = ST_CHECK_ID;
            end
         end
         ST_CHECK_ID: begin
            if (spi_rx[7:0] != DEVID_VALUE) begin
               error_d = 1'b1;
               state_d = ST_ERROR;
            end else begin
               state_d = ST_WR_FORMAT;
            end
         end
         ST_WR_FORMAT: begin
            spi_tx = {spi_cmd(1'b0, 1'b0, REG_DATA_FORMAT), 4'b0000, FULL_RES, 1'b0, RANGE, 48'h0};
            if (!issued_q && !spi_busy) begin
               spi_start = 1'b1;
               issued_d  = 1'b1;
            end else if (spi_done) begin
               issued_d = 1'b0;
               state_d  = ST_WR_POWER;
            end
         end
         ST_WR_POWER: begin
            spi_tx = {spi_cmd(1'b0, 1'b0, REG_POWER_CTL), POWER_MEASURE, 48'h0};
            if (!issued_q && !spi_busy) begin
               spi_start = 1'b1;
               issued_d  = 1'b1;
            end else if (spi_done) begin
               issued_d = 1'b0;
               state_d  = ST_WAIT_TIMER;
            end
         end
         ST_WAIT_TIMER: begin
            spi_len = 7'd56;
            spi_tx  = {spi_cmd(1'b1, 1'b1, REG_DATAX0), 56'h0};
            // Timer zeroes on the start cycle, so nCS falls land exactly
            // SAMPLE_PERIOD cycles apart; an overdue start fires at once.
            if (timer_q >= TIMER_THRESH && !spi_busy) begin
               spi_start = 1'b1;
               timer_d   = '0;
               state_d   = ST_BURST;
            end
         end
         ST_BURST: begin
            if (spi_done) state_d = ST_ACCUM;
         end
         ST_ACCUM: begin
            acc_x_d = acc_x_q + ACC_W'(raw_x);
            acc_y_d = acc_y_q + ACC_W'(raw_y);
            acc_z_d = acc_z_q + ACC_W'(raw_z);
            cnt_d   = cnt_inc;
            state_d = (cnt_inc == CNT_TARGET) ? ST_PUBLISH : ST_WAIT_TIMER;
         end
         ST_PUBLISH: begin
            x_d     = avg_out(acc_x_q);
            y_d     = avg_out(acc_y_q);
            z_d     = avg_out(acc_z_q);
            valid_d = 1'b1;
            acc_x_d = '0;
            acc_y_d = '0;
            acc_z_d = '0;
            cnt_d   = '0;
            state_d = ST_WAIT_TIMER;
         end
         ST_ERROR: begin
            state_d = ST_ERROR;
         end
         default: begin
            state_d = ST_READ_ID;
         end
      endcase
   end

   always_ff @(posedge ipClk) begin
      if (ipReset) begin
         state_q  <= ST_READ_ID;
         issued_q <= 1'b0;
         timer_q  <= '0;
         acc_x_q  <= '0;
         acc_y_q  <= '0;
         acc_z_q  <= '0;
         cnt_q    <= '0;
         x_q      <= '0;
         y_q      <= '0;
         z_q      <= '0;
         valid_q  <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         issued_q <= issued_d;
         timer_q  <= timer_d;
         acc_x_q  <= acc_x_d;
         acc_y_q  <= acc_y_d;
         acc_z_q  <= acc_z_d;
         cnt_q    <= cnt_d;
         x_q      <= x_d;
         y_q      <= y_d;
         z_q      <= z_d;
         valid_q  <= valid_d;
         error_q  <= error_d;
      end
   end

   assign opX     = x_q;
   assign opY     = y_q;
   assign opZ     = z_q;
   assign opValid = valid_q;
   assign opError = error_q;

endmodule

// File: tb/tb_adxl345_burst_reader.sv
// -----------------------------------------------------------------------------
// tb_adxl345_burst_reader
// Two instances: dut0 with default parameters, dut1 with AVG_LOG2=2 and
// SAMPLE_PERIOD=5000. Each has an ADXL345 slave model that answers DEVID and
// burst reads, logs every transaction and counts mode-3 timing violations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_adxl345_burst_reader;

   localparam int TCLK    = 10;
   localparam int CLK_DIV = 5;

   logic             clk = 1'b0;
   logic [1:0]       rst = 2'b11;
   logic [1:0][15:0] ox, oy, oz;
   logic [1:0]       ovld, oerr, ncs, sclk, sdi;
   logic [1:0]       sdo = 2'b00;

   int n_chk = 0;
   int n_err = 0;

   always #(TCLK/2) clk = ~clk;

   adxl345_burst_reader #(.CLOCK_DIV(CLK_DIV)) dut0 (
      .ipClk(clk), .ipReset(rst[0]), .opX(ox[0]), .opY(oy[0]), .opZ(oz[0]),
      .opValid(ovld[0]), .opError(oerr[0]), .nCS(ncs[0]), .SClk(sclk[0]),
      .SDI(sdi[0]), .SDO(sdo[0])
   );

   adxl345_burst_reader #(.CLOCK_DIV(CLK_DIV), .SAMPLE_PERIOD(5000), .AVG_LOG2(2)) dut1 (
      .ipClk(clk), .ipReset(rst[1]), .opX(ox[1]), .opY(oy[1]), .opZ(oz[1]),
      .opValid(ovld[1]), .opError(oerr[1]), .nCS(ncs[1]), .SClk(sclk[1]),
      .SDI(sdi[1]), .SDO(sdo[1])
   );

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Reply bytes {X0,X1,Y0,Y1,Z0,Z1} for burst number k of instance g.
   function automatic logic [47:0] burst_word(input int g, input int k);
      if (g == 0) return 48'h2301_00FF_FF7F;
      case (k % 4)
         0:       return 48'h0400_FFFF_6400;  // X=4  Y=-1 Z=100
         1:       return 48'h0500_FFFF_C800;  // X=5  Y=-1 Z=200
         2:       return 48'h0600_FFFF_2C01;  // X=6  Y=-1 Z=300
         default: return 48'hF9FF_FEFF_9001;  // X=-7 Y=-2 Z=400
      endcase
   endfunction

   for (genvar g = 0; g < 2; g++) begin : slv
      int          n_log = 0;
      logic [7:0]  log_cmd [64];
      logic [7:0]  log_b1  [64];
      int          log_bits[64];
      longint      log_fall[64];
      int          bits = 0;
      int          n_burst = 0;
      int          t_err = 0;
      bit          active = 0;
      bit          first_fall = 0;
      bit          rst_seen = 1;
      logic [7:0]  cur_cmd = 8'h00;
      logic [7:0]  devid = 8'hE5;
      logic [63:0] rx_sh = '0;
      logic [47:0] resp = '0;
      longint      t_fall = 0;
      longint      t_rise = -1000000;

      always @(posedge clk) if (rst[g]) rst_seen = 1;

      always @(negedge ncs[g]) begin
         if (!rst[g]) begin
            if (!rst_seen && (longint'($time) - t_rise) < 2*CLK_DIV*TCLK) t_err++;
            if (sclk[g] !== 1'b1) t_err++;
            rst_seen   = 0;
            active     = 1;
            first_fall = 1;
            t_fall     = longint'($time);
            bits       = 0;
            rx_sh      = '0;
            resp       = '0;
            cur_cmd    = 8'h00;
            sdo[g]     = 1'b0;
         end
      end

      always @(negedge sclk[g]) begin
         if (active && !rst[g]) begin
            if (first_fall) begin
               if (longint'($time) - t_fall != CLK_DIV*TCLK) t_err++;
               first_fall = 0;
            end
            if (bits >= 8) begin
               sdo[g] = resp[47];
               resp   = resp << 1;
            end
         end
      end

      always @(posedge sclk[g]) begin
         if (active && !rst[g]) begin
            rx_sh = {rx_sh[62:0], sdi[g]};
            bits++;
            if (bits == 8) begin
               cur_cmd = rx_sh[7:0];
               if (rx_sh[7:0] == 8'h80) resp = {devid, 40'h0};
               else if (rx_sh[7:0] == 8'hF2) begin
                  resp = burst_word(g, n_burst);
                  n_burst++;
               end else resp = '0;
            end
         end
      end

      always @(posedge ncs[g]) begin
         if (active) begin
            if (!rst[g] && sclk[g] !== 1'b1) t_err++;
            if (n_log < 64) begin
               log_bits[n_log] = bits;
               log_fall[n_log] = t_fall;
               log_cmd[n_log]  = (bits >= 8)  ? 8'(rx_sh >> (bits - 8))  : 8'h00;
               log_b1[n_log]   = (bits >= 16) ? 8'(rx_sh >> (bits - 16)) : 8'h00;
               n_log++;
            end
            active = 0;
            t_rise = longint'($time);
         end
      end
   end

   task automatic wait_log0(input string tag, input int n, input int max_cyc);
      int k;
      k = 0;
      while (slv[0].n_log < n && k < max_cyc) begin
         @(posedge clk);
         k++;
      end
      #1;
      check_eq(tag, 64'(slv[0].n_log >= n), 64'd1);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      fork
         begin : seq_dut0
            int k;
            int n;
            int lo_cnt;
            int v_cnt;
            repeat (3) @(posedge clk);
            #1;
            check_eq("rst_ncs",   ncs[0],  1);
            check_eq("rst_sclk",  sclk[0], 1);
            check_eq("rst_sdi",   sdi[0],  1);
            check_eq("rst_x",     ox[0],   0);
            check_eq("rst_y",     oy[0],   0);
            check_eq("rst_z",     oz[0],   0);
            check_eq("rst_valid", ovld[0], 0);
            check_eq("rst_err",   oerr[0], 0);
            @(negedge clk) rst[0] = 1'b0;

            wait_log0("wait_id", 1, 2000);
            check_eq("id_bits",  slv[0].log_bits[0], 16);
            check_eq("id_cmd",   slv[0].log_cmd[0],  8'h80);
            check_eq("id_valid", ovld[0], 0);
            check_eq("id_x",     ox[0],   0);

            wait_log0("wait_cfg", 3, 2000);
            check_eq("fmt_cmd",  slv[0].log_cmd[1],  8'h31);
            check_eq("fmt_val",  slv[0].log_b1[1],   8'h09);
            check_eq("fmt_bits", slv[0].log_bits[1], 16);
            check_eq("pwr_cmd",  slv[0].log_cmd[2],  8'h2D);
            check_eq("pwr_val",  slv[0].log_b1[2],   8'h08);

            k = 0;
            while (!ovld[0] && k < 3000) begin
               @(posedge clk);
               #1;
               k++;
            end
            check_eq("valid_seen", ovld[0], 1);
            check_eq("burst_cmd",  slv[0].log_cmd[3],  8'hF2);
            check_eq("burst_bits", slv[0].log_bits[3], 56);
            check_eq("out_x",      ox[0], 16'h0123);
            check_eq("out_y",      oy[0], 16'hFF00);
            check_eq("out_z",      oz[0], 16'h7FFF);
            check_eq("out_err",    oerr[0], 0);
            @(posedge clk);
            #1;
            check_eq("valid_1cyc", ovld[0], 0);
            check_eq("hold_x",     ox[0], 16'h0123);

            // Reset in the middle of the next burst, right after bit 30.
            k = 0;
            while (!(slv[0].active && slv[0].cur_cmd == 8'hF2 && slv[0].bits == 30) && k < 2000) begin
               @(posedge clk);
               #1;
               k++;
            end
            check_eq("mid_burst_seen", 64'(slv[0].bits == 30), 1);
            @(negedge clk) rst[0] = 1'b1;
            n = slv[0].n_log;
            @(posedge clk);
            #1;
            check_eq("abort_ncs",   ncs[0],  1);
            check_eq("abort_sclk",  sclk[0], 1);
            check_eq("abort_x",     ox[0],   0);
            check_eq("abort_y",     oy[0],   0);
            check_eq("abort_z",     oz[0],   0);
            check_eq("abort_valid", ovld[0], 0);
            @(negedge clk) rst[0] = 1'b0;
            wait_log0("wait_restart", n + 2, 2000);
            check_eq("abort_bits",   slv[0].log_bits[n],   30);
            check_eq("restart_cmd",  slv[0].log_cmd[n+1],  8'h80);
            check_eq("restart_bits", slv[0].log_bits[n+1], 16);

            // Wrong DEVID: controller must stop with opError and a quiet bus.
            @(negedge clk);
            slv[0].devid = 8'h00;
            rst[0] = 1'b1;
            @(negedge clk) rst[0] = 1'b0;
            n = slv[0].n_log;
            wait_log0("wait_bad_id", n + 1, 2000);
            check_eq("bad_id_cmd", slv[0].log_cmd[n], 8'h80);
            repeat (30) @(posedge clk);
            #1;
            check_eq("bad_id_err", oerr[0], 1);
            lo_cnt = 0;
            v_cnt  = 0;
            for (int i = 0; i < 10000; i++) begin
               @(posedge clk);
               #1;
               if (ncs[0] !== 1'b1) lo_cnt++;
               if (ovld[0] !== 1'b0) v_cnt++;
            end
            check_eq("bad_id_ncs_low", lo_cnt, 0);
            check_eq("bad_id_valid",   v_cnt,  0);
            check_eq("bad_id_no_txn",  slv[0].n_log, n + 1);
            check_eq("bad_id_sticky",  oerr[0], 1);
         end
         begin : seq_dut1
            int k;
            repeat (3) @(posedge clk);
            @(negedge clk) rst[1] = 1'b0;
            k = 0;
            while (!ovld[1] && k < 40000) begin
               @(posedge clk);
               #1;
               k++;
            end
            check_eq("avg_seen",   ovld[1], 1);
            check_eq("avg_bursts", slv[1].n_burst, 4);
            check_eq("avg_x",      ox[1], 16'h0002);
            check_eq("avg_y",      oy[1], 16'hFFFE);
            check_eq("avg_z",      oz[1], 16'h00FA);
            check_eq("avg_err",    oerr[1], 0);
            check_eq("avg_b0_cmd", slv[1].log_cmd[3], 8'hF2);
            check_eq("period_1", slv[1].log_fall[4] - slv[1].log_fall[3], 5000*TCLK);
            check_eq("period_2", slv[1].log_fall[5] - slv[1].log_fall[4], 5000*TCLK);
            check_eq("period_3", slv[1].log_fall[6] - slv[1].log_fall[5], 5000*TCLK);
            @(posedge clk);
            #1;
            check_eq("avg_valid_1cyc", ovld[1], 0);
         end
      join
      check_eq("timing_dut0", slv[0].t_err, 0);
      check_eq("timing_dut1", slv[1].t_err, 0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
